vector_alu_sequencer: RTL and testbench

VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

---
 rtl/vector_alu_sequencer_if.sv | 36 +++
 rtl/vector_alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_vector_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_alu_sequencer_if.sv
// Bundle of command, ALU-control and response signals between the sequencer and its environment.
interface vector_alu_sequencer_if #(
  parameter int BITS = 8,
  parameter int N    = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [2:0]          cmd_op;
  logic                cmd_scalar_sel;
  logic [BITS-1:0]     cmd_scalar;
  logic [2:0]          op_sel;
  logic                scalar_sel;
  logic [BITS-1:0]     scalar;
  logic                set;
  logic                en;
  logic [N*BITS-1:0]   S_in;
  logic [7:0]          S_len_in;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [N*BITS-1:0]   rsp_data;
  logic [7:0]          rsp_len;
  logic                busy;
  logic [15:0]         done_count;

  modport master (
    output cmd_valid, cmd_op, cmd_scalar_sel, cmd_scalar, S_in, S_len_in, rsp_ready,
    input  cmd_ready, op_sel, scalar_sel, scalar, set, en, rsp_valid, rsp_data, rsp_len,
           busy, done_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_scalar_sel, cmd_scalar, S_in, S_len_in, rsp_ready,
    output cmd_ready, op_sel, scalar_sel, scalar, set, en, rsp_valid, rsp_data, rsp_len,
           busy, done_count
  );
endinterface

// File: rtl/vector_alu_sequencer.sv
// Queues ALU commands, issues each as a one-cycle set pulse, waits ALU_LAT cycles and
// holds the captured result until the consumer accepts it; throughput one op per ALU_LAT+2 cycles.
module vector_alu_sequencer #(
  parameter int BITS    = 8,
  parameter int N       = 4,
  parameter int QDEPTH  = 4,
  parameter int ALU_LAT = 1
) (
  input logic                 clk,
  input logic                 rst,
  vector_alu_sequencer_if.slave bus
);
  localparam int             PW       = $clog2(QDEPTH);
  localparam logic [PW:0]    L_QDEPTH = (PW+1)'(QDEPTH);
  localparam logic [3:0]     L_LAT_M1 = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state;
  logic [2:0]          r_fifo_op [QDEPTH];
  logic                r_fifo_ss [QDEPTH];
  logic [BITS-1:0]     r_fifo_sc [QDEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW:0]         r_count;
  logic [3:0]          r_wait_cnt;
  logic [2:0]          r_op_sel;
  logic                r_scalar_sel;
  logic [BITS-1:0]     r_scalar;
  logic                r_set;
  logic                r_en;
  logic                r_rsp_valid;
  logic [N*BITS-1:0]   r_rsp_data;
  logic [7:0]          r_rsp_len;
  logic [15:0]         r_done_count;

  logic w_empty;
  logic w_hs;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_hs    = (r_state == RESP) && bus.rsp_ready;
  assign w_pop   = !w_empty && ((r_state == IDLE) || w_hs);
  // A pop in the same cycle frees the slot, so a full queue can still take a push.
  assign bus.cmd_ready = (r_count < L_QDEPTH) || w_pop;
  assign w_push  = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_op[r_wr_ptr] <= bus.cmd_op;
      r_fifo_ss[r_wr_ptr] <= bus.cmd_scalar_sel;
      r_fifo_sc[r_wr_ptr] <= bus.cmd_scalar;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_op_sel     <= '0;
      r_scalar_sel <= 1'b0;
      r_scalar     <= '0;
      r_set        <= 1'b0;
      r_en         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_len    <= '0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_op_sel     <= r_fifo_op[r_rd_ptr];
            r_scalar_sel <= r_fifo_ss[r_rd_ptr];
            r_scalar     <= r_fifo_sc[r_rd_ptr];
            r_set        <= 1'b1;
            r_en         <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_set      <= 1'b0;
          r_wait_cnt <= L_LAT_M1;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_rsp_data  <= bus.S_in;
            r_rsp_len   <= bus.S_len_in;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_done_count != 16'hFFFF) r_done_count <= r_done_count + 16'd1;
            if (w_pop) begin
              r_op_sel     <= r_fifo_op[r_rd_ptr];
              r_scalar_sel <= r_fifo_ss[r_rd_ptr];
              r_scalar     <= r_fifo_sc[r_rd_ptr];
              r_set        <= 1'b1;
              r_state      <= ISSUE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.op_sel     = r_op_sel;
  assign bus.scalar_sel = r_scalar_sel;
  assign bus.scalar     = r_scalar;
  assign bus.set        = r_set;
  assign bus.en         = r_en;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_len    = r_rsp_len;
  assign bus.done_count = r_done_count;
  assign bus.busy       = (r_state != IDLE) || !w_empty;
endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Directed bench for vector_alu_sequencer: single op, backpressure ordering, full-queue
// push/pop, stall stability, reset mid-op and done_count saturation.
module tb_vector_alu_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  vector_alu_sequencer_if #(.BITS(8), .N(4)) bus ();

  vector_alu_sequencer #(.BITS(8), .N(4), .QDEPTH(4), .ALU_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in ALU: each element = scalar + op, or bench-driven vectors when alu_fake=0.
  logic        alu_fake;
  logic [31:0] s_drv;
  logic [7:0]  len_drv;
  logic [7:0]  w_elem;
  always_comb begin
    w_elem = bus.scalar + {5'b0, bus.op_sel};
    bus.S_in     = alu_fake ? {4{w_elem}} : s_drv;
    bus.S_len_in = alu_fake ? 8'd4 : len_drv;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] sc);
    bit seen;
    bus.cmd_valid      = 1'b1;
    bus.cmd_op         = op;
    bus.cmd_scalar_sel = 1'b1;
    bus.cmd_scalar     = sc;
    tick();
    bus.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else tick();
    end
    chk("op_rsp_seen", 64'(seen), 64'd1);
    tick();
  endtask

  initial begin
    int  exp_rsp;
    int  next_op;
    bit  will_push;
    bit  saw_valid;
    bit  seen;

    total = 0;
    bad   = 0;
    rst = 1'b1;
    alu_fake = 1'b0;
    s_drv = '0;
    len_drv = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_scalar_sel = 1'b0;
    bus.cmd_scalar = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_set", 64'(bus.set), 64'd0);
    chk("rst_en", 64'(bus.en), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_done_count", 64'(bus.done_count), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single op with ALU_LAT=1
    s_drv = 32'hA5C3_1E77;
    len_drv = 8'd4;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd3;
    bus.cmd_scalar_sel = 1'b1;
    bus.cmd_scalar = 8'hFF;
    #1;
    chk("t1_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t1_set_before", 64'(bus.set), 64'd0);
    chk("t1_busy_queued", 64'(bus.busy), 64'd1);
    tick();
    chk("t1_set_pulse", 64'(bus.set), 64'd1);
    chk("t1_en", 64'(bus.en), 64'd1);
    chk("t1_op_sel", 64'(bus.op_sel), 64'd3);
    chk("t1_scalar_sel", 64'(bus.scalar_sel), 64'd1);
    chk("t1_scalar", 64'(bus.scalar), 64'hFF);
    tick();
    chk("t1_set_drop", 64'(bus.set), 64'd0);
    chk("t1_rsp_early", 64'(bus.rsp_valid), 64'd0);
    chk("t1_hold_op", 64'(bus.op_sel), 64'd3);
    tick();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_rsp_data", 64'(bus.rsp_data), 64'hA5C3_1E77);
    chk("t1_rsp_len", 64'(bus.rsp_len), 64'd4);
    tick();
    chk("t1_rsp_clear", 64'(bus.rsp_valid), 64'd0);
    chk("t1_done_count", 64'(bus.done_count), 64'd1);
    chk("t1_busy_idle", 64'(bus.busy), 64'd0);
    chk("t1_en_stays", 64'(bus.en), 64'd1);

    // Reset, then backpressure with ops 0..7
    rst = 1'b1;
    #1;
    chk("rst2_en", 64'(bus.en), 64'd0);
    chk("rst2_done", 64'(bus.done_count), 64'd0);
    tick();
    rst = 1'b0;
    alu_fake = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_scalar_sel = 1'b0;
    bus.cmd_scalar = 8'd0;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_op = 3'(i);
      #1;
      chk("bp_ready_accept", 64'(bus.cmd_ready), 64'd1);
      tick();
    end
    bus.cmd_op = 3'd5;
    #1;
    chk("bp_ready_full", 64'(bus.cmd_ready), 64'd0);
    chk("bp_count_full", 64'(dut.r_count), 64'd4);
    chk("bp_rsp0_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_rsp0_data", 64'(bus.rsp_data), 64'h0000_0000);
    bus.rsp_ready = 1'b1;
    #1;
    chk("full_pushpop_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    chk("full_pushpop_count", 64'(dut.r_count), 64'd4);
    chk("full_pushpop_set", 64'(bus.set), 64'd1);
    chk("full_pushpop_op", 64'(bus.op_sel), 64'd1);
    next_op = 6;
    bus.cmd_op = 3'd6;
    exp_rsp = 1;
    for (int c = 0; c < 100 && exp_rsp < 8; c++) begin
      if (bus.rsp_valid) begin
        chk("bp_order", 64'(bus.rsp_data), 64'({4{8'(exp_rsp)}}));
        exp_rsp++;
      end
      will_push = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (will_push) begin
        if (next_op == 7) bus.cmd_valid = 1'b0;
        else begin
          next_op++;
          bus.cmd_op = 3'(next_op);
        end
      end
    end
    chk("bp_all_rsp", 64'(exp_rsp), 64'd8);
    chk("bp_done_count", 64'(bus.done_count), 64'd8);
    chk("bp_busy_end", 64'(bus.busy), 64'd0);

    // Stall stability while S_in toggles
    alu_fake = 1'b0;
    s_drv = 32'h1122_3344;
    len_drv = 8'd4;
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd2;
    tick();
    bus.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else tick();
    end
    chk("stall_rsp_seen", 64'(seen), 64'd1);
    for (int c = 0; c < 10; c++) begin
      s_drv = ~s_drv;
      tick();
      chk("stall_data", 64'(bus.rsp_data), 64'h1122_3344);
    end
    chk("stall_valid_held", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    tick();
    chk("stall_done_count", 64'(bus.done_count), 64'd9);

    // Reset while in WAIT with two commands queued
    alu_fake = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd1;
    tick();
    bus.cmd_op = 3'd2;
    tick();
    bus.cmd_op = 3'd4;
    tick();
    bus.cmd_valid = 1'b0;
    chk("rw_state_wait", 64'(dut.r_state), 64'd2);
    chk("rw_queued", 64'(dut.r_count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rw_set", 64'(bus.set), 64'd0);
    chk("rw_en", 64'(bus.en), 64'd0);
    chk("rw_op_sel", 64'(bus.op_sel), 64'd0);
    chk("rw_scalar_sel", 64'(bus.scalar_sel), 64'd0);
    chk("rw_scalar", 64'(bus.scalar), 64'd0);
    chk("rw_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rw_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rw_rsp_len", 64'(bus.rsp_len), 64'd0);
    chk("rw_done_count", 64'(bus.done_count), 64'd0);
    chk("rw_busy", 64'(bus.busy), 64'd0);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.rsp_valid || bus.set) saw_valid = 1'b1;
    end
    chk("rw_no_rsp", 64'(saw_valid), 64'd0);

    // done_count saturation
    force dut.r_done_count = 16'hFFFD;
    tick();
    release dut.r_done_count;
    tick();
    chk("sat_preload", 64'(bus.done_count), 64'hFFFD);
    run_op(3'd1, 8'h10);
    chk("sat_1", 64'(bus.done_count), 64'hFFFE);
    run_op(3'd2, 8'h20);
    chk("sat_2", 64'(bus.done_count), 64'hFFFF);
    run_op(3'd3, 8'h30);
    chk("sat_3", 64'(bus.done_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
